// File: rtl/uart_peripheral.sv
// uart_peripheral
//   Memory-mapped 8N1 UART that sits beside data memory. A store strobe
//   (uart_start) queues a byte into a TX FIFO. A load strobe (uart_read_en)
//   pops the RX FIFO head. Both FIFOs are FIFO_DEPTH deep.
//
// Ports
//   clk, reset      : system clock; asynchronous active-high reset
//   uart_start      : push tx_data into the TX FIFO at this edge
//   tx_data[7:0]    : byte to transmit
//   uart_read_en    : pop the RX FIFO head at this edge
//   rd_data[31:0]   : {24'h0, RX head}, or all ones when RX is empty (combinational)
//   rx              : serial input, asynchronous to clk
//   tx              : serial output, registered, idles high
//   tx_full         : TX FIFO full
//   rx_empty        : RX FIFO empty
//   tx_overflow     : sticky flag, a write was dropped on a full TX FIFO
//   rx_overflow     : sticky flag, a received byte was dropped on a full RX FIFO
//   frame_err       : sticky flag, a stop bit was sampled low
module uart_peripheral #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_start,
  input  logic [7:0]  tx_data,
  input  logic        uart_read_en,
  output logic [31:0] rd_data,
  input  logic        rx,
  output logic        tx,
  output logic        tx_full,
  output logic        rx_empty,
  output logic        tx_overflow,
  output logic        rx_overflow,
  output logic        frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_e;

  // TX FIFO and transmitter state
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [AW:0]   tx_cnt_q, tx_cnt_d;
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_baud_q, tx_baud_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_q, tx_d;
  logic          tx_overflow_q, tx_overflow_d;
  logic          tx_empty, tx_pop, tx_push;

  // RX FIFO and receiver state
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [AW:0]   rx_cnt_q, rx_cnt_d;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_baud_q, rx_baud_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_meta_q, rx_s_q;
  logic          rx_overflow_q, rx_overflow_d;
  logic          frame_err_q, frame_err_d;
  logic          rx_full, rx_done, rx_pop, rx_push;

  assign tx_full     = (tx_cnt_q == DEPTH_C);
  assign tx_empty    = (tx_cnt_q == '0);
  assign rx_full     = (rx_cnt_q == DEPTH_C);
  assign rx_empty    = (rx_cnt_q == '0);
  assign tx          = tx_q;
  assign tx_overflow = tx_overflow_q;
  assign rx_overflow = rx_overflow_q;
  assign frame_err   = frame_err_q;
  assign rd_data     = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_mem[rx_rd_ptr_q]};

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign tx_push = uart_start && (!tx_full || tx_pop);
  assign rx_pop  = uart_read_en && !rx_empty;
  assign rx_push = rx_done && (!rx_full || rx_pop);

  // Transmitter: START and the first data bit are set up one cycle early so
  // the registered tx output changes exactly on bit boundaries.
  always_comb begin
    tx_state_d    = tx_state_q;
    tx_baud_d     = tx_baud_q;
    tx_bit_d      = tx_bit_q;
    tx_shift_d    = tx_shift_q;
    tx_d          = tx_q;
    tx_pop        = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_mem[tx_rd_ptr_q];
          tx_d       = 1'b0;
          tx_baud_d  = '0;
          tx_state_d = T_START;
        end
      end
      T_START: begin
        if (tx_baud_q == BIT_END) begin
          tx_baud_d  = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = T_DATA;
        end else begin
          tx_baud_d = tx_baud_q + 1'b1;
        end
      end
      T_DATA: begin
        if (tx_baud_q == BIT_END) begin
          tx_baud_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = T_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_d       = tx_shift_q[1];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end else begin
          tx_baud_d = tx_baud_q + 1'b1;
        end
      end
      T_STOP: begin
        if (tx_baud_q == BIT_END) begin
          tx_baud_d = '0;
          // Chain straight into the next frame when data is waiting.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_mem[tx_rd_ptr_q];
            tx_d       = 1'b0;
            tx_state_d = T_START;
          end else begin
            tx_state_d = T_IDLE;
          end
        end else begin
          tx_baud_d = tx_baud_q + 1'b1;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  // Receiver: all decisions are taken on the synchronized rx_s_q.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_baud_d   = rx_baud_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    frame_err_d = frame_err_q;
    rx_done     = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (!rx_s_q) begin
          rx_baud_d  = '0;
          rx_state_d = R_START;
        end
      end
      R_START: begin
        // Re-check at mid start bit so short glitches are rejected.
        if (rx_baud_q == HALF_END) begin
          rx_baud_d = '0;
          rx_bit_d  = '0;
          rx_state_d = rx_s_q ? R_IDLE : R_DATA;
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      R_DATA: begin
        if (rx_baud_q == BIT_END) begin
          rx_baud_d  = '0;
          rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = R_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      R_STOP: begin
        if (rx_baud_q == BIT_END) begin
          rx_baud_d = '0;
          if (rx_s_q) begin
            rx_done    = 1'b1;
            rx_state_d = R_IDLE;
          end else begin
            frame_err_d = 1'b1;
            rx_state_d  = R_BREAK;
          end
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      R_BREAK: begin
        // Hold off until the line returns high so a break is not seen as a start bit.
        if (rx_s_q) rx_state_d = R_IDLE;
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    tx_wr_ptr_d   = tx_push ? tx_wr_ptr_q + 1'b1 : tx_wr_ptr_q;
    tx_rd_ptr_d   = tx_pop  ? tx_rd_ptr_q + 1'b1 : tx_rd_ptr_q;
    tx_cnt_d      = tx_cnt_q;
    if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + 1'b1;
    if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - 1'b1;
    tx_overflow_d = tx_overflow_q | (uart_start && !tx_push);

    rx_wr_ptr_d   = rx_push ? rx_wr_ptr_q + 1'b1 : rx_wr_ptr_q;
    rx_rd_ptr_d   = rx_pop  ? rx_rd_ptr_q + 1'b1 : rx_rd_ptr_q;
    rx_cnt_d      = rx_cnt_q;
    if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + 1'b1;
    if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - 1'b1;
    rx_overflow_d = rx_overflow_q | (rx_done && !rx_push);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr_ptr_q   <= '0;
      tx_rd_ptr_q   <= '0;
      tx_cnt_q      <= '0;
      tx_state_q    <= T_IDLE;
      tx_baud_q     <= '0;
      tx_bit_q      <= '0;
      tx_q          <= 1'b1;
      tx_overflow_q <= 1'b0;
      rx_wr_ptr_q   <= '0;
      rx_rd_ptr_q   <= '0;
      rx_cnt_q      <= '0;
      rx_state_q    <= R_IDLE;
      rx_baud_q     <= '0;
      rx_bit_q      <= '0;
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_overflow_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      tx_wr_ptr_q   <= tx_wr_ptr_d;
      tx_rd_ptr_q   <= tx_rd_ptr_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_state_q    <= tx_state_d;
      tx_baud_q     <= tx_baud_d;
      tx_bit_q      <= tx_bit_d;
      tx_q          <= tx_d;
      tx_overflow_q <= tx_overflow_d;
      rx_wr_ptr_q   <= rx_wr_ptr_d;
      rx_rd_ptr_q   <= rx_rd_ptr_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_state_q    <= rx_state_d;
      rx_baud_q     <= rx_baud_d;
      rx_bit_q      <= rx_bit_d;
      rx_meta_q     <= rx;
      rx_s_q        <= rx_meta_q;
      rx_overflow_q <= rx_overflow_d;
      frame_err_q   <= frame_err_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= tx_data;
    if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_shift_q;
    tx_shift_q <= tx_shift_d;
    rx_shift_q <= rx_shift_d;
  end

endmodule

// File: tb/tb_uart_peripheral.sv
module tb_uart_peripheral;
  localparam int CPB   = 16;
  localparam int DEPTH = 16;

  logic        clk;
  logic        reset;
  logic        uart_start;
  logic [7:0]  tx_data;
  logic        uart_read_en;
  logic [31:0] rd_data;
  logic        rx;
  logic        rx_drv;
  logic        loop_en;
  logic        tx;
  logic        tx_full;
  logic        rx_empty;
  logic        tx_overflow;
  logic        rx_overflow;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  logic       exp_bits[$];
  logic [7:0] exp_bytes[$];

  assign rx = loop_en ? tx : rx_drv;

  uart_peripheral #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .uart_start(uart_start), .tx_data(tx_data),
    .uart_read_en(uart_read_en), .rd_data(rd_data), .rx(rx), .tx(tx),
    .tx_full(tx_full), .rx_empty(rx_empty), .tx_overflow(tx_overflow),
    .rx_overflow(rx_overflow), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
  endtask

  // Expected tx line level for every cycle of one 8N1 frame.
  task automatic push_frame_bits(input logic [7:0] b);
    logic v;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) v = 1'b0;
      else if (i == 9) v = 1'b1;
      else v = b[i-1];
      repeat (CPB) exp_bits.push_back(v);
    end
  endtask

  // Drive start bit plus 8 data bits on rx_drv; caller drives the stop bit.
  task automatic drive_rx_head(input logic [7:0] b);
    rx_drv = 1'b0;
    repeat (CPB) step();
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (CPB) step();
    end
  endtask

  task automatic test_reset();
    drive_rx_head(8'h81);
    rx_drv = 1'b1;
    repeat (CPB) step();
    checks++;
    if (rx_empty !== 1'b0) begin errors++; $display("FAIL pre_reset_rx_empty: got %b expected 0", rx_empty); end
    for (int i = 0; i < 18; i++) begin
      uart_start = 1'b1;
      tx_data = 8'h00;
      step();
    end
    uart_start = 1'b0;
    repeat (30) step();
    checks++;
    if (tx_overflow !== 1'b1) begin errors++; $display("FAIL pre_reset_tx_overflow: got %b expected 1", tx_overflow); end
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL pre_reset_tx_low: got %b expected 0", tx); end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++;
    if (rd_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_rd_data: got %h expected ffffffff", rd_data); end
    checks++;
    if (rx_empty !== 1'b1) begin errors++; $display("FAIL reset_rx_empty: got %b expected 1", rx_empty); end
    checks++;
    if (tx_full !== 1'b0) begin errors++; $display("FAIL reset_tx_full: got %b expected 0", tx_full); end
    checks++;
    if ({tx_overflow, rx_overflow, frame_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {tx_overflow, rx_overflow, frame_err});
    end
    repeat (2) step();
    reset = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL post_reset_tx_idle cycle %0d: got %b expected 1", i, tx); end
    end
  endtask

  task automatic test_tx_single();
    logic e;
    exp_bits.delete();
    push_frame_bits(8'hA5);
    repeat (10) exp_bits.push_back(1'b1);
    tx_data = 8'hA5;
    uart_start = 1'b1;
    step();
    uart_start = 1'b0;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL tx_single_write_edge: got %b expected 1", tx); end
    for (int c = 0; exp_bits.size() > 0; c++) begin
      step();
      e = exp_bits.pop_front();
      checks++;
      if (tx !== e) begin errors++; $display("FAIL tx_single cycle %0d: got %b expected %b", c, tx, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    int c;
    exp_bits.delete();
    for (int i = 0; i < 17; i++) push_frame_bits(8'(i));
    repeat (10) exp_bits.push_back(1'b1);
    c = 0;
    while (exp_bits.size() > 0) begin
      if (c < 18) begin
        uart_start = 1'b1;
        tx_data = 8'(c);
      end else begin
        uart_start = 1'b0;
      end
      step();
      if (c >= 1) begin
        e = exp_bits.pop_front();
        checks++;
        if (tx !== e) begin errors++; $display("FAIL b2b_tx cycle %0d: got %b expected %b", c, tx, e); end
      end
      if (c == 15) begin
        checks++;
        if (tx_full !== 1'b0) begin errors++; $display("FAIL b2b_not_full: got %b expected 0", tx_full); end
      end
      if (c == 16) begin
        checks++;
        if (tx_full !== 1'b1) begin errors++; $display("FAIL b2b_full: got %b expected 1", tx_full); end
        checks++;
        if (tx_overflow !== 1'b0) begin errors++; $display("FAIL b2b_no_overflow_yet: got %b expected 0", tx_overflow); end
      end
      if (c == 17) begin
        checks++;
        if (tx_overflow !== 1'b1) begin errors++; $display("FAIL b2b_overflow: got %b expected 1", tx_overflow); end
      end
      c++;
    end
  endtask

  task automatic test_rx_byte();
    logic [7:0] eb;
    exp_bytes.push_back(8'h3C);
    drive_rx_head(8'h3C);
    rx_drv = 1'b1;
    repeat (6) step();
    checks++;
    if (rx_empty !== 1'b1) begin errors++; $display("FAIL rx_before_stop_sample: got %b expected 1", rx_empty); end
    repeat (10) step();
    checks++;
    if (rx_empty !== 1'b0) begin errors++; $display("FAIL rx_after_stop_sample: got %b expected 0", rx_empty); end
    uart_read_en = 1'b1;
    #1;
    eb = exp_bytes.pop_front();
    checks++;
    if (rd_data !== {24'h0, eb}) begin errors++; $display("FAIL rx_rd_data: got %h expected %h", rd_data, {24'h0, eb}); end
    step();
    uart_read_en = 1'b0;
    checks++;
    if (rx_empty !== 1'b1) begin errors++; $display("FAIL rx_empty_after_pop: got %b expected 1", rx_empty); end
    checks++;
    if (rd_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rx_rd_data_empty: got %h expected ffffffff", rd_data); end
  endtask

  task automatic test_rx_errors();
    rx_drv = 1'b0;
    repeat (4) step();
    rx_drv = 1'b1;
    repeat (40) step();
    checks++;
    if (rx_empty !== 1'b1) begin errors++; $display("FAIL glitch_rx_empty: got %b expected 1", rx_empty); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL glitch_frame_err: got %b expected 0", frame_err); end
    drive_rx_head(8'h55);
    rx_drv = 1'b0;
    repeat (CPB) step();
    rx_drv = 1'b1;
    repeat (20) step();
    checks++;
    if (frame_err !== 1'b1) begin errors++; $display("FAIL bad_stop_frame_err: got %b expected 1", frame_err); end
    checks++;
    if (rx_empty !== 1'b1) begin errors++; $display("FAIL bad_stop_rx_empty: got %b expected 1", rx_empty); end
  endtask

  task automatic test_loopback();
    logic [7:0] eb;
    do_reset();
    exp_bytes.delete();
    loop_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      uart_start = 1'b1;
      tx_data = 8'hC0 + 8'(i * 3);
      if (i < DEPTH) exp_bytes.push_back(tx_data);
      step();
    end
    uart_start = 1'b0;
    repeat (17 * 10 * CPB + 100) step();
    checks++;
    if (rx_overflow !== 1'b1) begin errors++; $display("FAIL loop_rx_overflow: got %b expected 1", rx_overflow); end
    checks++;
    if (tx_overflow !== 1'b0) begin errors++; $display("FAIL loop_tx_overflow: got %b expected 0", tx_overflow); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL loop_frame_err: got %b expected 0", frame_err); end
    uart_read_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      eb = exp_bytes.pop_front();
      checks++;
      if (rd_data !== {24'h0, eb}) begin
        errors++; $display("FAIL loop_read %0d: got %h expected %h", i, rd_data, {24'h0, eb});
      end
      step();
    end
    uart_read_en = 1'b0;
    checks++;
    if (rx_empty !== 1'b1) begin errors++; $display("FAIL loop_rx_empty: got %b expected 1", rx_empty); end
    checks++;
    if (rd_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL loop_rd_data_empty: got %h expected ffffffff", rd_data); end
    loop_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    uart_start = 1'b0;
    tx_data = 8'h00;
    uart_read_en = 1'b0;
    rx_drv = 1'b1;
    loop_en = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    repeat (4) step();
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_rx_byte();
    test_rx_errors();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
